// File: rtl/word_serializer.sv
// LSB-first parallel-to-serial converter with registered serial outputs.
// Optional `SER_BACK2BACK_EN: accept the next word in the MSB cycle for gapless streaming.
module word_serializer #(
  parameter int WIDTH = 12
) (
  input  logic             t_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sfirst,
  output logic             sbusy,
  output logic             word_done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n, sfirst_n, sbusy_n, done_n;
  logic             last, accept;

  // cnt tracks the index of the bit currently presented on sout
  assign last = (state == SHIFT) && (cnt == LAST);

`ifdef SER_BACK2BACK_EN
  assign din_ready = !rst && ((state == IDLE) || last);
`else
  assign din_ready = !rst && (state == IDLE);
`endif

  assign accept = din_valid && din_ready;

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      sout      <= 1'b0;
      sfirst    <= 1'b0;
      sbusy     <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      sreg      <= sreg_n;
      cnt       <= cnt_n;
      sout      <= sout_n;
      sfirst    <= sfirst_n;
      sbusy     <= sbusy_n;
      word_done <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    sreg_n   = sreg;
    cnt_n    = cnt;
    sout_n   = 1'b0;
    sfirst_n = 1'b0;
    sbusy_n  = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n  = SHIFT;
          sreg_n   = din;
          cnt_n    = '0;
          sout_n   = din[0];
          sfirst_n = 1'b1;
          sbusy_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (accept) begin
          // only reachable in the MSB cycle when back-to-back is enabled
          sreg_n   = din;
          cnt_n    = '0;
          sout_n   = din[0];
          sfirst_n = 1'b1;
          sbusy_n  = 1'b1;
        end else if (!last) begin
          sreg_n  = sreg >> 1;
          cnt_n   = cnt + CW'(1);
          sout_n  = sreg[1];
          sbusy_n = 1'b1;
          done_n  = (cnt_n == LAST);
        end else begin
          state_n = IDLE;
          sreg_n  = '0;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
